csr_timer_bank: RTL and testbench

- Parametrised timer/interrupt bank for the CSR subsystem. Provides NCHAN independent LoongArch-style countdown timers, each with TCFG/TVAL/TICLR semantics, a shared tick prescaler, per-channel pending interrupt lines and a 64-bit stable counter for rdcnt.
- Sits beside the CSR register file. CSR write/read decode selects channel and register. The pending lines feed ESTAT interrupt bits.

---
 rtl/csr_timer_bank_if.sv | 31 +++
 rtl/csr_timer_bank.sv | 106 ++++++++++
 tb/tb_csr_timer_bank.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/csr_timer_bank_if.sv
// CSR-side bus of the timer bank: write/read decode from the CSR file,
// plus interrupt and stable-counter outputs.
interface csr_timer_bank_if #(
    parameter int unsigned NCHAN = 2
) ();
    localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    logic             wr_en;
    logic [CW-1:0]    wr_chan;
    logic             wr_sel;
    logic             wr_me;
    logic [31:0]      wr_mask;
    logic [31:0]      wr_data;
    logic [CW-1:0]    rd_chan;
    logic [1:0]       rd_sel;
    logic [31:0]      rd_data;
    logic [NCHAN-1:0] timer_irq;
    logic             irq_any;
    logic [31:0]      counter_hi;
    logic [31:0]      counter_lo;

    modport master (
        output wr_en, wr_chan, wr_sel, wr_me, wr_mask, wr_data, rd_chan, rd_sel,
        input  rd_data, timer_irq, irq_any, counter_hi, counter_lo
    );

    modport slave (
        input  wr_en, wr_chan, wr_sel, wr_me, wr_mask, wr_data, rd_chan, rd_sel,
        output rd_data, timer_irq, irq_any, counter_hi, counter_lo
    );
endinterface

// File: rtl/csr_timer_bank.sv
// NCHAN countdown timers with TCFG/TVAL/TICLR semantics, a shared tick
// prescaler, per-channel pending interrupts and a 64-bit stable counter.
module csr_timer_bank #(
    parameter int unsigned NCHAN    = 2,
    parameter int unsigned TIMESIZE = 32,
    parameter int unsigned PRESCALE = 1
) (
    input  logic           clk,
    input  logic           reset,
    csr_timer_bank_if.slave bus
);
    localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [TIMESIZE-1:0] tcfg_q [NCHAN];
    logic [TIMESIZE-1:0] tcfg_d [NCHAN];
    logic [TIMESIZE-1:0] tval_q [NCHAN];
    logic [TIMESIZE-1:0] tval_d [NCHAN];
    logic [NCHAN-1:0]    pend_q, pend_d;
    logic                irq_any_q;
    logic [PW-1:0]       pre_q, pre_d;
    logic                tick;
    logic [63:0]         cnt_q, snap_q;
    logic [31:0]         m_eff;

    function automatic logic [TIMESIZE-1:0] reload(input logic [TIMESIZE-1:0] cfg);
        return {cfg[TIMESIZE-1:2], 2'b00};
    endfunction

    assign tick  = (pre_q == PW'(PRESCALE - 1));
    assign pre_d = tick ? '0 : pre_q + PW'(1);
    assign m_eff = bus.wr_me ? bus.wr_mask : '1;

    // Per-channel next state: a TCFG write overrides the countdown; expiry beats TICLR.
    always_comb begin
        logic                wr_hit;
        logic                fire;
        logic [TIMESIZE-1:0] wcfg;
        for (int i = 0; i < NCHAN; i++) begin
            tcfg_d[i] = tcfg_q[i];
            tval_d[i] = tval_q[i];
            pend_d[i] = pend_q[i];
            wr_hit    = bus.wr_en && (bus.wr_chan == CW'(i));
            fire      = 1'b0;
            wcfg      = TIMESIZE'((32'(tcfg_q[i]) & ~m_eff) | (bus.wr_data & m_eff));
            if (wr_hit && !bus.wr_sel) begin
                tcfg_d[i] = wcfg;
                tval_d[i] = reload(wcfg);
            end else begin
                if (tick && tcfg_q[i][0]) begin
                    if (tval_q[i] > TIMESIZE'(1)) begin
                        tval_d[i] = tval_q[i] - TIMESIZE'(1);
                    end else if (tval_q[i] == TIMESIZE'(1)) begin
                        fire      = 1'b1;
                        tval_d[i] = tcfg_q[i][1] ? reload(tcfg_q[i]) : '0;
                    end
                end
                if (wr_hit && bus.wr_sel && bus.wr_data[0] && m_eff[0]) pend_d[i] = 1'b0;
                if (fire) pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCHAN; i++) begin
                tcfg_q[i] <= '0;
                tval_q[i] <= '0;
            end
            pend_q    <= '0;
            irq_any_q <= 1'b0;
            pre_q     <= '0;
            cnt_q     <= '0;
            snap_q    <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                tcfg_q[i] <= tcfg_d[i];
                tval_q[i] <= tval_d[i];
            end
            pend_q    <= pend_d;
            irq_any_q <= |pend_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_q + 64'd1;
            snap_q    <= cnt_q;
        end
    end

    // Read mux; unmatched channel or TICLR/reserved select reads as zero.
    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NCHAN; i++) begin
            if (bus.rd_chan == CW'(i)) begin
                case (bus.rd_sel)
                    2'd0:    bus.rd_data = 32'(tcfg_q[i]);
                    2'd1:    bus.rd_data = 32'(tval_q[i]);
                    default: bus.rd_data = '0;
                endcase
            end
        end
    end

    assign bus.timer_irq  = pend_q;
    assign bus.irq_any    = irq_any_q;
    assign bus.counter_hi = snap_q[63:32];
    assign bus.counter_lo = snap_q[31:0];
endmodule

// File: tb/tb_csr_timer_bank.sv
// Two bank instances (3ch/32b/prescale 1 and 2ch/16b/prescale 4) driven by
// shared directed and random CSR traffic, compared against an arithmetic model.
module tb_csr_timer_bank;
    localparam int unsigned NA = 3;
    localparam int unsigned NB = 2;

    logic clk = 1'b0;
    logic reset;
    always #20 clk = ~clk;

    csr_timer_bank_if #(.NCHAN(NA)) ifa ();
    csr_timer_bank_if #(.NCHAN(NB)) ifb ();

    csr_timer_bank #(.NCHAN(NA), .TIMESIZE(32), .PRESCALE(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    csr_timer_bank #(.NCHAN(NB), .TIMESIZE(16), .PRESCALE(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    logic        t_wen, t_sel, t_me;
    logic [31:0] t_mask, t_data;
    int unsigned t_chan, t_rchan, t_rsel;

    assign ifa.wr_en   = t_wen;         assign ifb.wr_en   = t_wen;
    assign ifa.wr_sel  = t_sel;         assign ifb.wr_sel  = t_sel;
    assign ifa.wr_me   = t_me;          assign ifb.wr_me   = t_me;
    assign ifa.wr_mask = t_mask;        assign ifb.wr_mask = t_mask;
    assign ifa.wr_data = t_data;        assign ifb.wr_data = t_data;
    assign ifa.wr_chan = 2'(t_chan);    assign ifb.wr_chan = 1'(t_chan);
    assign ifa.rd_chan = 2'(t_rchan);   assign ifb.rd_chan = 1'(t_rchan);
    assign ifa.rd_sel  = 2'(t_rsel);    assign ifb.rd_sel  = 2'(t_rsel);

    int unsigned     m_cfg  [2][4];
    int unsigned     m_val  [2][4];
    bit              m_pend [2][4];
    longint unsigned m_cyc;
    int              n_vec = 0;
    int              n_err = 0;

    function automatic int unsigned nch(int d); return (d == 0) ? NA : NB; endfunction
    function automatic int unsigned tsz(int d); return (d == 0) ? 32 : 16; endfunction
    function automatic int unsigned psc(int d); return (d == 0) ? 1 : 4; endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
                m_cfg[d][c] = 0; m_val[d][c] = 0; m_pend[d][c] = 1'b0;
            end
        m_cyc = 0;
    endfunction

    // One clock edge of the bank, from the register rules and the current inputs.
    function automatic void model_edge();
        for (int d = 0; d < 2; d++) begin
            int unsigned tm   = (tsz(d) == 32) ? 32'hFFFF_FFFF : ((32'd1 << tsz(d)) - 1);
            int unsigned m    = t_me ? t_mask : 32'hFFFF_FFFF;
            int unsigned chw  = t_chan % ((d == 0) ? 4 : 2);
            bit          tick = (m_cyc % psc(d)) == longint'(psc(d) - 1);
            for (int c = 0; c < int'(nch(d)); c++) begin
                bit hit  = t_wen && (chw == c);
                bit fire = 1'b0;
                if (hit && !t_sel) begin
                    m_cfg[d][c] = ((m_cfg[d][c] & ~m) | (t_data & m)) & tm;
                    m_val[d][c] = m_cfg[d][c] & ~32'd3;
                end else begin
                    if (tick && (m_cfg[d][c] & 1) != 0) begin
                        if (m_val[d][c] > 1) m_val[d][c] = m_val[d][c] - 1;
                        else if (m_val[d][c] == 1) begin
                            fire = 1'b1;
                            m_val[d][c] = ((m_cfg[d][c] & 2) != 0) ? (m_cfg[d][c] & ~32'd3) : 0;
                        end
                    end
                    if (hit && t_sel && (t_data & m & 1) != 0) m_pend[d][c] = 1'b0;
                    if (fire) m_pend[d][c] = 1'b1;
                end
            end
        end
        m_cyc++;
    endfunction

    function automatic longint unsigned rd_exp(int d, int unsigned c, int unsigned s);
        if (c >= nch(d)) return 0;
        if (s == 0) return m_cfg[d][c];
        if (s == 1) return m_val[d][c];
        return 0;
    endfunction

    function automatic longint unsigned irq_exp(int d);
        longint unsigned v = 0;
        for (int c = 0; c < int'(nch(d)); c++) if (m_pend[d][c]) v = v | (64'd1 << c);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        longint unsigned cexp = (m_cyc == 0) ? 0 : m_cyc - 1;
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 4; s++) begin
                t_rchan = c; t_rsel = s;
                #1;
                chk($sformatf("rd_a c%0d s%0d", c, s), 64'(ifa.rd_data), rd_exp(0, c, s));
                chk($sformatf("rd_b c%0d s%0d", c, s), 64'(ifb.rd_data), rd_exp(1, c % 2, s));
            end
        chk("irq_a", 64'(ifa.timer_irq), irq_exp(0));
        chk("irq_b", 64'(ifb.timer_irq), irq_exp(1));
        chk("any_a", 64'(ifa.irq_any), 64'(irq_exp(0) != 0));
        chk("any_b", 64'(ifb.irq_any), 64'(irq_exp(1) != 0));
        chk("cnt_a", {ifa.counter_hi, ifa.counter_lo}, cexp);
        chk("cnt_b", {ifb.counter_hi, ifb.counter_lo}, cexp);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        #1;
        t_wen = 1'b0;
        check_all();
    endtask

    task automatic wr(input int unsigned ch, input logic sel, input logic me,
                      input logic [31:0] mask, input logic [31:0] data);
        t_wen = 1'b1; t_chan = ch; t_sel = sel; t_me = me; t_mask = mask; t_data = data;
        step();
    endtask

    initial begin
        bit found;
        int n;
        t_wen = 1'b0; t_sel = 1'b0; t_me = 1'b0; t_mask = '0; t_data = '0;
        t_chan = 0; t_rchan = 0; t_rsel = 0;
        model_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_irq_any", 64'(ifa.irq_any), 64'd0);

        // one-shot ch0, InitVal 4
        wr(0, 1'b0, 1'b0, '0, 32'h11);
        repeat (20) step();
        chk("oneshot_irq", 64'(ifa.timer_irq[0]), 64'd1);

        // periodic ch1, InitVal 2, then clear and let it re-assert
        wr(1, 1'b0, 1'b0, '0, 32'h0B);
        repeat (10) step();
        wr(1, 1'b1, 1'b0, '0, 32'h1);
        repeat (20) step();

        // masked write clears En only, full write resumes
        wr(0, 1'b0, 1'b0, '0, 32'h41);
        wr(0, 1'b0, 1'b1, 32'h1, 32'h0);
        repeat (5) step();
        wr(0, 1'b0, 1'b0, '0, 32'h41);
        repeat (5) step();

        // out-of-range channel for the 3-channel bank
        wr(3, 1'b0, 1'b0, '0, 32'hFF);
        wr(3, 1'b1, 1'b0, '0, 32'h1);

        // expiry and TICLR on the same edge: set wins
        wr(0, 1'b1, 1'b0, '0, 32'h1);
        wr(0, 1'b0, 1'b0, '0, 32'h07);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_val[0][0] == 1 && m_pend[0][0]) found = 1'b1;
            else step();
        end
        chk("coll_found", 64'(found), 64'd1);
        wr(0, 1'b1, 1'b0, '0, 32'h1);
        chk("coll_keep", 64'(ifa.timer_irq[0]), 64'd1);
        wr(0, 1'b1, 1'b0, '0, 32'h1);
        chk("coll_clr", 64'(ifa.timer_irq[0]), 64'd0);

        // random CSR traffic
        repeat (250) begin
            if ($urandom_range(0, 3) == 0) begin
                t_wen  = 1'b1;
                t_chan = $urandom_range(0, 3);
                t_sel  = 1'($urandom_range(0, 1));
                t_me   = 1'($urandom_range(0, 1));
                t_mask = $urandom;
                t_data = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
            end
            step();
        end

        // mid-run reset, counter restarts
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_cnt", {ifa.counter_hi, ifa.counter_lo}, 64'd0);
        step();
        step();
        chk("cnt_lo_two", 64'(ifa.counter_lo), 64'd1);

        // prescale 4, InitVal 1: four ticks, 13..16 cycles depending on phase
        wr(0, 1'b0, 1'b0, '0, 32'h5);
        n = 0;
        while (n < 100 && ifb.timer_irq[0] !== 1'b1) begin
            step();
            n++;
        end
        chk("pre4_latency_ok", 64'(n >= 13 && n <= 16), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
